// File: rtl/regfile_bypass.sv
// Register file with hardwired-zero r0, same-cycle write-to-read bypass,
// a run-gated clear sweep that zeroes r1..r(NREGS-1) one entry per edge,
// and a registered debug read port.
module regfile_bypass #(
  parameter int BITS  = 8,
  parameter int RBITS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             we,
  input  logic [RBITS-1:0] rd,
  input  logic [BITS-1:0]  rd_din,
  input  logic [RBITS-1:0] rs1,
  input  logic [RBITS-1:0] rs2,
  output logic [BITS-1:0]  rs1_dout,
  output logic [BITS-1:0]  rs2_dout,
  input  logic             clr_req,
  output logic             clr_busy,
  input  logic [RBITS-1:0] dbg_sel,
  output logic [BITS-1:0]  dbg_dout
);

  localparam int NREGS = 2 ** RBITS;
  localparam logic [RBITS-1:0] LAST = RBITS'(NREGS - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t           state, state_n;
  logic [RBITS-1:0] idx, idx_n;
  logic             sweep_we;
  logic             write_ok;

  // r0 is never stored; it reads as zero through the read muxes.
  logic [BITS-1:0]  mem [1:NREGS-1];

  assign clr_busy = (state == SWEEP);
  assign write_ok = run && we && (rd != '0) && !clr_busy;

  // FSM state and sweep index register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  // Next-state logic: sweep advances only on run-enabled edges.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    sweep_we = 1'b0;
    case (state)
      IDLE: begin
        if (run && clr_req) begin
          state_n = SWEEP;
          idx_n   = RBITS'(1);
        end
      end
      SWEEP: begin
        if (run) begin
          sweep_we = 1'b1;
          idx_n    = idx + RBITS'(1);
          if (idx == LAST) state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        idx_n   = '0;
      end
    endcase
  end

  // Storage: sweep clears take the slot; normal writes are blocked while busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 1; i < NREGS; i++) mem[RBITS'(i)] <= '0;
    end else if (sweep_we) begin
      mem[idx] <= '0;
    end else if (write_ok) begin
      mem[rd] <= rd_din;
    end
  end

  // Read port 1: zero for r0, bypass a committing write, else storage.
  always_comb begin
    rs1_dout = '0;
    if (rs1 != '0) begin
      if (write_ok && (rd == rs1)) rs1_dout = rd_din;
      else                         rs1_dout = mem[rs1];
    end
  end

  // Read port 2: same decode as port 1, evaluated independently.
  always_comb begin
    rs2_dout = '0;
    if (rs2 != '0) begin
      if (write_ok && (rd == rs2)) rs2_dout = rd_din;
      else                         rs2_dout = mem[rs2];
    end
  end

  // Debug port: pre-write stored value, one edge of latency, ignores run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                dbg_dout <= '0;
    else if (dbg_sel == '0) dbg_dout <= '0;
    else                    dbg_dout <= mem[dbg_sel];
  end

endmodule
